reef_game_engine: RTL and testbench

- Parametrised successor to the single-player block controller.
- Owns player position, N_SHARK hazard lanes and N_BOTTLE collectible lanes, with per-lane speed, left-edge wrap and respawn.
- Performs per-frame hit detection, scoring and an IDLE/PLAY/DEAD/WIN game FSM.
- Renders a registered 12-bit pixel for the VGA display controller from hCount/vCount.

---
 rtl/reef_game_pkg.sv | 57 +++++
 rtl/reef_object_lane.sv | 47 ++++
 rtl/reef_game_engine.sv | 215 +++++++++++++++++++++
 tb/tb_reef_game_engine.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reef_game_pkg.sv
// Shared types, playfield bounds, sprite geometry and colours for the reef game engine.
package reef_game_pkg;

   localparam int unsigned POS_W   = 10;
   localparam int unsigned DIFF_W  = POS_W + 1;
   localparam int unsigned SPD_W   = 3;
   localparam int unsigned RGB_W   = 12;
   localparam int unsigned SCORE_W = 4;
   localparam int unsigned SUM_W   = SCORE_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_PLAY = 2'b01,
      ST_DEAD = 2'b10,
      ST_WIN  = 2'b11
   } game_state_t;

   localparam logic [POS_W-1:0] X_LEFT   = 10'd144;
   localparam logic [POS_W-1:0] X_RIGHT  = 10'd784;
   localparam logic [POS_W-1:0] Y_MIN    = 10'd40;
   localparam logic [POS_W-1:0] Y_MAX    = 10'd512;
   localparam logic [POS_W-1:0] SAND_TOP = 10'd490;
   localparam logic [POS_W-1:0] SAND_BOT = 10'd520;

   localparam logic [POS_W-1:0] PLAYER_X0 = 10'd200;
   localparam logic [POS_W-1:0] PLAYER_Y0 = 10'd250;

   localparam logic [POS_W-1:0] SHARK_HIT_X  = 10'd10;
   localparam logic [POS_W-1:0] SHARK_HIT_Y  = 10'd10;
   localparam logic [POS_W-1:0] BOTTLE_HIT_X = 10'd6;
   localparam logic [POS_W-1:0] BOTTLE_HIT_Y = 10'd8;

   localparam logic [POS_W-1:0] PLAYER_HALF   = 10'd5;
   localparam logic [POS_W-1:0] SHARK_HALF_X  = 10'd10;
   localparam logic [POS_W-1:0] SHARK_HALF_Y  = 10'd5;
   localparam logic [POS_W-1:0] BOTTLE_HALF_X = 10'd2;
   localparam logic [POS_W-1:0] BOTTLE_HALF_Y = 10'd4;

   localparam logic [RGB_W-1:0] COL_BLACK  = 12'h000;
   localparam logic [RGB_W-1:0] COL_PLAYER = 12'hF00;
   localparam logic [RGB_W-1:0] COL_SAND   = 12'hFF0;
   localparam logic [RGB_W-1:0] COL_SHARK  = 12'h058;
   localparam logic [RGB_W-1:0] COL_BOTTLE = 12'hAEF;
   localparam logic [RGB_W-1:0] COL_PLAY   = 12'h00F;
   localparam logic [RGB_W-1:0] COL_DEAD   = 12'hF80;
   localparam logic [RGB_W-1:0] COL_WIN    = 12'hFFF;

   // |a-b| <= d, evaluated on a widened difference so nothing wraps.
   function automatic logic near(input logic [POS_W-1:0] a,
                                 input logic [POS_W-1:0] b,
                                 input logic [POS_W-1:0] d);
      logic [DIFF_W-1:0] diff;
      diff = (a >= b) ? DIFF_W'(a) - DIFF_W'(b) : DIFF_W'(b) - DIFF_W'(a);
      return diff <= DIFF_W'(d);
   endfunction

endpackage

// File: rtl/reef_object_lane.sv
// One horizontally moving object on a fixed row: reload, respawn, wrap/move,
// plus hit test against the player and a sprite-box pixel flag.
module reef_object_lane
   import reef_game_pkg::*;
#(
   parameter logic [POS_W-1:0] INIT_X = 10'd0,
   parameter logic [POS_W-1:0] POS_Y  = 10'd0,
   parameter logic [SPD_W-1:0] SPD    = 3'd1,
   parameter logic [POS_W-1:0] HIT_X  = 10'd0,
   parameter logic [POS_W-1:0] HIT_Y  = 10'd0,
   parameter logic [POS_W-1:0] BOX_X  = 10'd0,
   parameter logic [POS_W-1:0] BOX_Y  = 10'd0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             reload,
   input  logic             respawn,
   input  logic             move,
   input  logic [POS_W-1:0] px,
   input  logic [POS_W-1:0] py,
   input  logic [POS_W-1:0] h_count,
   input  logic [POS_W-1:0] v_count,
   output logic [POS_W-1:0] x,
   output logic             hit_c,
   output logic             in_box_c
);

   // Respawn wins over motion so a collected object reappears exactly at the right edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x <= INIT_X;
      end else if (reload) begin
         x <= INIT_X;
      end else if (respawn) begin
         x <= X_RIGHT;
      end else if (move) begin
         if (DIFF_W'(x) < DIFF_W'(X_LEFT) + DIFF_W'(SPD))
            x <= X_RIGHT;
         else
            x <= x - POS_W'(SPD);
      end
   end

   assign hit_c    = near(px, x, HIT_X) && near(py, POS_Y, HIT_Y);
   assign in_box_c = near(h_count, x, BOX_X) && near(v_count, POS_Y, BOX_Y);

endmodule

// File: rtl/reef_game_engine.sv
// Reef game core: player, shark/bottle lanes, hit/score FSM and registered pixel output.
// Optional LIVES_EN macro enables a three-life budget before DEAD.
module reef_game_engine
   import reef_game_pkg::*;
#(
   parameter int unsigned N_SHARK  = 2,
   parameter int unsigned N_BOTTLE = 2,
   parameter logic [N_SHARK*POS_W-1:0]  SHARK_X    = {10'd440, 10'd220},
   parameter logic [N_SHARK*POS_W-1:0]  SHARK_Y    = {10'd330, 10'd135},
   parameter logic [N_SHARK*SPD_W-1:0]  SHARK_SPD  = {3'd2, 3'd3},
   parameter logic [N_BOTTLE*POS_W-1:0] BOTTLE_X   = {10'd170, 10'd250},
   parameter logic [N_BOTTLE*POS_W-1:0] BOTTLE_Y   = {10'd200, 10'd440},
   parameter logic [N_BOTTLE*SPD_W-1:0] BOTTLE_SPD = {3'd1, 3'd2},
   parameter int unsigned WIN_COUNT = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick,
   input  logic               start,
   input  logic               up,
   input  logic               down,
   input  logic               bright,
   input  logic [POS_W-1:0]   hCount,
   input  logic [POS_W-1:0]   vCount,
   output logic [RGB_W-1:0]   rgb,
   output logic [SCORE_W-1:0] score,
   output logic [1:0]         state,
   output logic [1:0]         lives
);

   localparam logic [SCORE_W-1:0] WIN_SCORE = SCORE_W'(WIN_COUNT);

   game_state_t          state_q, state_nxt;
   logic [SCORE_W-1:0]   score_nxt;
   logic [SUM_W-1:0]     score_sum;
   logic [POS_W-1:0]     player_y, player_y_nxt;
   logic                 reload_shark, reload_bottle, move_lanes;
   logic [N_BOTTLE-1:0]  respawn_bottle;
   logic [N_SHARK-1:0]   shark_hit_c, shark_box_c;
   logic [N_BOTTLE-1:0]  bottle_hit_c, bottle_box_c;
   logic [2:0]           bottle_cnt_c;
   logic [RGB_W-1:0]     rgb_c;
   logic                 player_box_c, sand_c;
`ifdef LIVES_EN
   logic [1:0]           lives_nxt;
`endif

   for (genvar i = 0; i < int'(N_SHARK); i++) begin : g_shark
      reef_object_lane #(
         .INIT_X (SHARK_X[i*POS_W +: POS_W]),
         .POS_Y  (SHARK_Y[i*POS_W +: POS_W]),
         .SPD    (SHARK_SPD[i*SPD_W +: SPD_W]),
         .HIT_X  (SHARK_HIT_X),
         .HIT_Y  (SHARK_HIT_Y),
         .BOX_X  (SHARK_HALF_X),
         .BOX_Y  (SHARK_HALF_Y)
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .reload   (reload_shark),
         .respawn  (1'b0),
         .move     (move_lanes),
         .px       (PLAYER_X0),
         .py       (player_y),
         .h_count  (hCount),
         .v_count  (vCount),
         .x        (),
         .hit_c    (shark_hit_c[i]),
         .in_box_c (shark_box_c[i])
      );
   end

   for (genvar i = 0; i < int'(N_BOTTLE); i++) begin : g_bottle
      reef_object_lane #(
         .INIT_X (BOTTLE_X[i*POS_W +: POS_W]),
         .POS_Y  (BOTTLE_Y[i*POS_W +: POS_W]),
         .SPD    (BOTTLE_SPD[i*SPD_W +: SPD_W]),
         .HIT_X  (BOTTLE_HIT_X),
         .HIT_Y  (BOTTLE_HIT_Y),
         .BOX_X  (BOTTLE_HALF_X),
         .BOX_Y  (BOTTLE_HALF_Y)
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .reload   (reload_bottle),
         .respawn  (respawn_bottle[i]),
         .move     (move_lanes),
         .px       (PLAYER_X0),
         .py       (player_y),
         .h_count  (hCount),
         .v_count  (vCount),
         .x        (),
         .hit_c    (bottle_hit_c[i]),
         .in_box_c (bottle_box_c[i])
      );
   end

   always_comb begin
      bottle_cnt_c = '0;
      for (int i = 0; i < int'(N_BOTTLE); i++)
         bottle_cnt_c = bottle_cnt_c + 3'(bottle_hit_c[i]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         score    <= '0;
         player_y <= PLAYER_Y0;
`ifdef LIVES_EN
         lives    <= 2'd3;
`endif
      end else begin
         state_q  <= state_nxt;
         score    <= score_nxt;
         player_y <= player_y_nxt;
`ifdef LIVES_EN
         lives    <= lives_nxt;
`endif
      end
   end

`ifndef LIVES_EN
   assign lives = 2'd0;
`endif

   assign state = state_q;

   // Game FSM: start beats tick; hits are judged on positions before this tick's motion.
   always_comb begin
      state_nxt      = state_q;
      score_nxt      = score;
      player_y_nxt   = player_y;
      reload_shark   = 1'b0;
      reload_bottle  = 1'b0;
      move_lanes     = 1'b0;
      respawn_bottle = '0;
      score_sum      = SUM_W'(score) + SUM_W'(bottle_cnt_c);
`ifdef LIVES_EN
      lives_nxt      = lives;
`endif
      if (start) begin
         state_nxt     = ST_PLAY;
         score_nxt     = '0;
         player_y_nxt  = PLAYER_Y0;
         reload_shark  = 1'b1;
         reload_bottle = 1'b1;
`ifdef LIVES_EN
         lives_nxt     = 2'd3;
`endif
      end else if (state_q == ST_PLAY && tick) begin
         if (|shark_hit_c) begin
`ifdef LIVES_EN
            if (lives > 2'd1) begin
               lives_nxt    = lives - 2'd1;
               player_y_nxt = PLAYER_Y0;
               reload_shark = 1'b1;
            end else begin
               lives_nxt = 2'd0;
               state_nxt = ST_DEAD;
            end
`else
            state_nxt = ST_DEAD;
`endif
         end else begin
            respawn_bottle = bottle_hit_c;
            move_lanes     = 1'b1;
            if (score_sum >= SUM_W'(WIN_COUNT)) begin
               score_nxt = WIN_SCORE;
               state_nxt = ST_WIN;
            end else begin
               score_nxt = SCORE_W'(score_sum);
            end
            if (up && !down)
               player_y_nxt = (player_y > Y_MIN) ? player_y - 10'd1 : Y_MIN;
            else if (down && !up)
               player_y_nxt = (player_y < Y_MAX) ? player_y + 10'd1 : Y_MAX;
         end
      end
   end

   assign player_box_c = near(hCount, PLAYER_X0, PLAYER_HALF) &&
                         near(vCount, player_y, PLAYER_HALF);
   assign sand_c = (hCount >= X_LEFT) && (hCount <= X_RIGHT) &&
                   (vCount >= SAND_TOP) && (vCount <= SAND_BOT);

   // Sprite priority: blanking, player, sand, sharks, bottles, then state background.
   always_comb begin
      rgb_c = COL_BLACK;
      if (!bright)
         rgb_c = COL_BLACK;
      else if (player_box_c)
         rgb_c = COL_PLAYER;
      else if (sand_c)
         rgb_c = COL_SAND;
      else if (|shark_box_c)
         rgb_c = COL_SHARK;
      else if (|bottle_box_c)
         rgb_c = COL_BOTTLE;
      else begin
         case (state_q)
            ST_IDLE: rgb_c = COL_BLACK;
            ST_PLAY: rgb_c = COL_PLAY;
            ST_DEAD: rgb_c = COL_DEAD;
            ST_WIN:  rgb_c = COL_WIN;
            default: rgb_c = COL_BLACK;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rgb <= '0;
      else     rgb <= rgb_c;
   end

endmodule

// File: tb/tb_reef_game_engine.sv
// Self-checking bench for reef_game_engine: render vector table plus hand-written game sequences.
module tb_reef_game_engine;

   logic clk = 1'b0;
   logic rst, tick, start, up, down, bright;
   logic [9:0] h_count, v_count;

   logic [11:0] rgb_d, rgb_h, rgb_c, rgb_w, rgb_e;
   logic [3:0]  score_d, score_h, score_c, score_w, score_e;
   logic [1:0]  state_d, state_h, state_c, state_w, state_e;
   logic [1:0]  lives_d, lives_h, lives_c, lives_w, lives_e;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];

   typedef struct packed {
      logic        bright;
      logic [9:0]  h;
      logic [9:0]  v;
      logic [11:0] rgb;
   } pix_vec_t;

   pix_vec_t vecs [16];

   always #5 clk = ~clk;

   reef_game_engine u_def (
      .clk(clk), .rst(rst), .tick(tick), .start(start), .up(up), .down(down),
      .bright(bright), .hCount(h_count), .vCount(v_count),
      .rgb(rgb_d), .score(score_d), .state(state_d), .lives(lives_d));

   reef_game_engine #(.SHARK_X({10'd440, 10'd215}), .SHARK_Y({10'd330, 10'd250})) u_hit (
      .clk(clk), .rst(rst), .tick(tick), .start(start), .up(up), .down(down),
      .bright(bright), .hCount(h_count), .vCount(v_count),
      .rgb(rgb_h), .score(score_h), .state(state_h), .lives(lives_h));

   reef_game_engine #(.SHARK_Y({10'd600, 10'd600}), .BOTTLE_Y({10'd600, 10'd600})) u_clamp (
      .clk(clk), .rst(rst), .tick(tick), .start(start), .up(up), .down(down),
      .bright(bright), .hCount(h_count), .vCount(v_count),
      .rgb(rgb_c), .score(score_c), .state(state_c), .lives(lives_c));

   reef_game_engine #(.WIN_COUNT(2), .BOTTLE_X({10'd203, 10'd205}),
                      .BOTTLE_Y({10'd250, 10'd250})) u_win (
      .clk(clk), .rst(rst), .tick(tick), .start(start), .up(up), .down(down),
      .bright(bright), .hCount(h_count), .vCount(v_count),
      .rgb(rgb_w), .score(score_w), .state(state_w), .lives(lives_w));

   reef_game_engine #(.WIN_COUNT(8), .BOTTLE_X({10'd203, 10'd205}),
                      .BOTTLE_Y({10'd250, 10'd250})) u_win8 (
      .clk(clk), .rst(rst), .tick(tick), .start(start), .up(up), .down(down),
      .bright(bright), .hCount(h_count), .vCount(v_count),
      .rgb(rgb_e), .score(score_e), .state(state_e), .lives(lives_e));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; tick = 1'b0; start = 1'b0; up = 1'b0; down = 1'b0;
      bright = 1'b0; h_count = '0; v_count = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic do_tick(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic show_pixel(input logic [9:0] h, input logic [9:0] v);
      bright = 1'b1; h_count = h; v_count = v;
      @(negedge clk);
   endtask

   initial begin
      vecs[0]  = '{1'b0, 10'd200, 10'd250, 12'h000};
      vecs[1]  = '{1'b1, 10'd200, 10'd250, 12'hF00};
      vecs[2]  = '{1'b1, 10'd205, 10'd255, 12'hF00};
      vecs[3]  = '{1'b1, 10'd206, 10'd250, 12'h00F};
      vecs[4]  = '{1'b1, 10'd300, 10'd500, 12'hFF0};
      vecs[5]  = '{1'b1, 10'd144, 10'd490, 12'hFF0};
      vecs[6]  = '{1'b1, 10'd143, 10'd500, 12'h00F};
      vecs[7]  = '{1'b1, 10'd784, 10'd520, 12'hFF0};
      vecs[8]  = '{1'b1, 10'd300, 10'd521, 12'h00F};
      vecs[9]  = '{1'b1, 10'd220, 10'd135, 12'h058};
      vecs[10] = '{1'b1, 10'd230, 10'd140, 12'h058};
      vecs[11] = '{1'b1, 10'd231, 10'd135, 12'h00F};
      vecs[12] = '{1'b1, 10'd250, 10'd440, 12'hAEF};
      vecs[13] = '{1'b1, 10'd252, 10'd444, 12'hAEF};
      vecs[14] = '{1'b1, 10'd253, 10'd440, 12'h00F};
      vecs[15] = '{1'b1, 10'd170, 10'd196, 12'hAEF};

      // Reset state and idle freeze
      rst = 1'b1; tick = 1'b0; start = 1'b0; up = 1'b0; down = 1'b0;
      bright = 1'b0; h_count = '0; v_count = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset_state", 32'(state_d), 32'd0);
      check("reset_score", 32'(score_d), 32'd0);
      check("reset_rgb", 32'(rgb_d), 32'h000);
      check("reset_player_y", 32'(u_def.player_y), 32'd250);
      check("reset_score_clamp", 32'(score_c), 32'd0);
`ifdef LIVES_EN
      check("reset_lives", 32'(lives_d), 32'd3);
`else
      check("reset_lives_def", 32'(lives_d), 32'd0);
      check("reset_lives_hit", 32'(lives_h), 32'd0);
      check("reset_lives_clamp", 32'(lives_c), 32'd0);
      check("reset_lives_win", 32'(lives_w), 32'd0);
      check("reset_lives_win8", 32'(lives_e), 32'd0);
`endif
      do_tick(10);
      check("idle_state", 32'(state_d), 32'd0);
      check("idle_shark0_x", 32'(u_def.g_shark[0].u_lane.x), 32'd220);
      check("idle_shark1_x", 32'(u_def.g_shark[1].u_lane.x), 32'd440);
      check("idle_bottle0_x", 32'(u_def.g_bottle[0].u_lane.x), 32'd250);
      check("idle_bottle1_x", 32'(u_def.g_bottle[1].u_lane.x), 32'd170);
      show_pixel(10'd600, 10'd100);
      check("idle_bg", 32'(rgb_d), 32'h000);

      // Render table in PLAY, one-cycle latency through the scoreboard
      bright = 1'b0;
      do_start();
      check("start_state", 32'(state_d), 32'd1);
      check("start_score", 32'(score_d), 32'd0);
      for (int i = 0; i < 16; i++) begin
         bright = vecs[i].bright; h_count = vecs[i].h; v_count = vecs[i].v;
         exp_q.push_back(32'(vecs[i].rgb));
         @(negedge clk);
         check($sformatf("render_%0d", i), 32'(rgb_d), exp_q.pop_front());
      end

      // Left-edge wrap of shark lane 0
      do_reset();
      do_start();
      for (int k = 1; k <= 26; k++) begin
         exp_q.push_back((k < 26) ? 32'(220 - 3 * k) : 32'd784);
         do_tick(1);
         check($sformatf("wrap_tick_%0d", k), 32'(u_def.g_shark[0].u_lane.x), exp_q.pop_front());
      end
      check("wrap_state", 32'(state_d), 32'd1);

      // Player clamp at both bounds
      do_reset();
      do_start();
      up = 1'b1;
      do_tick(300);
      check("clamp_top", 32'(u_clamp.player_y), 32'd40);
      down = 1'b1;
      do_tick(5);
      check("clamp_both_hold", 32'(u_clamp.player_y), 32'd40);
      up = 1'b0;
      do_tick(480);
      check("clamp_bottom", 32'(u_clamp.player_y), 32'd512);
      up = 1'b1;
      do_tick(5);
      check("clamp_both_hold_bot", 32'(u_clamp.player_y), 32'd512);
      down = 1'b0;
      do_tick(1);
      check("clamp_up_one", 32'(u_clamp.player_y), 32'd511);
      check("clamp_state", 32'(state_c), 32'd1);
      show_pixel(10'd600, 10'd100);
      check("clamp_bg_play", 32'(rgb_c), 32'h00F);

      // Shark hit on the third tick
      do_reset();
      do_start();
      do_tick(1);
      check("hit_t1_state", 32'(state_h), 32'd1);
      check("hit_t1_x", 32'(u_hit.g_shark[0].u_lane.x), 32'd212);
      do_tick(1);
      check("hit_t2_state", 32'(state_h), 32'd1);
      check("hit_t2_x", 32'(u_hit.g_shark[0].u_lane.x), 32'd209);
      do_tick(1);
`ifdef LIVES_EN
      check("lives_hit1_lives", 32'(lives_h), 32'd2);
      check("lives_hit1_state", 32'(state_h), 32'd1);
      check("lives_hit1_py", 32'(u_hit.player_y), 32'd250);
      check("lives_hit1_x", 32'(u_hit.g_shark[0].u_lane.x), 32'd215);
      do_tick(3);
      check("lives_hit2_lives", 32'(lives_h), 32'd1);
      check("lives_hit2_state", 32'(state_h), 32'd1);
      do_tick(3);
      check("lives_hit3_lives", 32'(lives_h), 32'd0);
      check("lives_hit3_state", 32'(state_h), 32'd2);
`else
      check("hit_t3_state", 32'(state_h), 32'd2);
      check("hit_t3_x", 32'(u_hit.g_shark[0].u_lane.x), 32'd209);
      check("hit_lives", 32'(lives_h), 32'd0);
      do_tick(1);
      check("dead_frozen_x0", 32'(u_hit.g_shark[0].u_lane.x), 32'd209);
      check("dead_frozen_x1", 32'(u_hit.g_shark[1].u_lane.x), 32'd436);
      check("dead_frozen_py", 32'(u_hit.player_y), 32'd250);
      check("dead_state", 32'(state_h), 32'd2);
`endif
      show_pixel(10'd600, 10'd100);
      check("dead_bg", 32'(rgb_h), 32'hF80);
      bright = 1'b0;
      do_start();
      check("restart_state", 32'(state_h), 32'd1);
      check("restart_score", 32'(score_h), 32'd0);
      check("restart_x", 32'(u_hit.g_shark[0].u_lane.x), 32'd215);

      // Double bottle pickup: WIN at WIN_COUNT=2, PLAY at WIN_COUNT=8
      do_reset();
      do_start();
      do_tick(1);
      check("win_score", 32'(score_w), 32'd2);
      check("win_state", 32'(state_w), 32'd3);
      check("win_bottle0_x", 32'(u_win.g_bottle[0].u_lane.x), 32'd784);
      check("win_bottle1_x", 32'(u_win.g_bottle[1].u_lane.x), 32'd784);
      check("win8_score", 32'(score_e), 32'd2);
      check("win8_state", 32'(state_e), 32'd1);
      do_tick(1);
      check("win_frozen_score", 32'(score_w), 32'd2);
      check("win_frozen_state", 32'(state_w), 32'd3);
      show_pixel(10'd600, 10'd100);
      check("win_bg", 32'(rgb_w), 32'hFFF);
      check("win8_bg", 32'(rgb_e), 32'h00F);
      bright = 1'b0;
      do_start();
      check("win_restart_state", 32'(state_w), 32'd1);
      check("win_restart_score", 32'(score_w), 32'd0);

      // Asynchronous reset mid-game, checked before the next clock edge
      do_reset();
      do_start();
      down = 1'b1;
      do_tick(1);
      down = 1'b0;
      show_pixel(10'd200, 10'd251);
      check("pre_rst_rgb", 32'(rgb_d), 32'hF00);
      check("pre_rst_py", 32'(u_def.player_y), 32'd251);
      #2 rst = 1'b1;
      #1;
      check("async_rst_state", 32'(state_d), 32'd0);
      check("async_rst_rgb", 32'(rgb_d), 32'h000);
      check("async_rst_py", 32'(u_def.player_y), 32'd250);
      check("async_rst_x", 32'(u_def.g_shark[0].u_lane.x), 32'd220);
      @(negedge clk);
      rst = 1'b0;
      bright = 1'b0;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
